decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised instruction-decode stage for the five-stage MIPS pipeline, sitting between the IF/ID and ID/EX boundaries. It contains a 2-read/1-write register file with synchronous reset, write-through bypass and hardwired `$0`. It also provides 3-way operand forwarding, a branch comparator, the branch-target adder, selectable sign/zero immediate extension, and an ID/EX pipeline register with stall, flush and valid tracking. It supersedes the fixed 32-bit, reset-less decode stage.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; must be ≥ 16.
- `ADDR_W`, 5, register address width; register count is 2^ADDR_W.
- `PC_W`, 32, program-counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `InstrD`  in  32  instruction in decode.
- `PCPlus4D`  in  PC_W  PC+4 of the instruction in decode.
- `ValidD`  in  1  the instruction in decode is real, not a bubble.
- `ExtZeroD`  in  1  1 = zero-extend the immediate, 0 = sign-extend it.
- `ForwardAD`, `ForwardBD`  in  2  operand source: 0 = register file, 1 = `ALUOutM`, 2 = `ResultW`, 3 = register file.
- `ALUOutM`  in  DATA_W  memory-stage ALU result.
- `ResultW`  in  DATA_W  writeback data.
- `WriteRegW`  in  ADDR_W  writeback address.
- `RegWriteW`  in  1  writeback enable.
- `StallE`  in  1  hold the ID/EX register.
- `FlushE`  in  1  load a bubble into ID/EX.
- `Op`, `Funct`  out  6  `InstrD[31:26]`, `InstrD[5:0]`.
- `RsD`, `RtD`  out  ADDR_W  low ADDR_W bits of `InstrD[25:21]` and `InstrD[20:16]`.
- `EqualD`  out  1  the two forwarded operands are equal (combinational).
- `PCBranchD`  out  PC_W  branch target (combinational).
- `A_E`, `B_E`, `SignImmE`  out  DATA_W  registered operands and extended immediate.
- `RsE`, `RtE`, `RdE`  out  ADDR_W  registered register addresses.
- `ShamtE`  out  5  registered `InstrD[10:6]`.
- `ValidE`  out  1  ID/EX holds a real instruction.

## Operation
Register file:
- Write occurs on the clock edge when `RegWriteW` is high and `WriteRegW` ≠ 0.
- Writes to address 0 are discarded; a read of address 0 always returns 0.
- Reads are combinational.
- Write-through bypass: a read returns `ResultW` in the same cycle when `RegWriteW` is high, `WriteRegW` equals the read address, and the address is ≠ 0.

Forwarding and compare:
- `RD1f`/`RD2f` are selected per `ForwardAD`/`ForwardBD`.
- `EqualD = (RD1f == RD2f)`, full DATA_W width.

Immediate:
- `InstrD[15:0]` is extended to DATA_W.
- Sign-extension replicates bit 15; zero-extension pads with zeros.

Branch target:
- `PCBranchD = PCPlus4D + (SignImm << 2)`, truncated to PC_W.
- The sign-extended immediate is always used for the target, regardless of `ExtZeroD`.

ID/EX register update priority, per edge:
1. `reset`: all ID/EX fields and every register-file entry become 0; `ValidE` = 0.
2. `FlushE`: all fields become 0 and `ValidE` = 0, even if `StallE` is also high.
3. `StallE`: all fields hold.
4. Otherwise: load `RD1f`, `RD2f`, the extended immediate, `RsD`, `RtD`, `RdD`, shamt and `ValidD`.

Register-file writes are independent of stall and flush; only `reset` suppresses them.

## Timing
- Reset values: `A_E`, `B_E`, `SignImmE`, `RsE`, `RtE`, `RdE`, `ShamtE`, `ValidE` and all registers are 0.
- Combinational outputs follow their inputs: `Op`, `Funct`, `RsD`, `RtD`, `EqualD`, `PCBranchD`.
- Decode-to-execute latency is exactly 1 cycle.
- A writeback in cycle N is visible to a decode read in cycle N through the bypass, and is captured into `A_E`/`B_E` at edge N+1.
- Reset asserted mid-operation takes effect at the next edge and overrides a simultaneous write.
- Reset released: the first non-reset edge behaves as a normal update.

## Structure
- Shared package `decode_pkg`:
  - `FWD_RF = 2'd0`, `FWD_MEM = 2'd1`, `FWD_WB = 2'd2`.
  - A packed struct `idex_t` for the ID/EX fields.
- Sub-module `regfile_2r1w`:
  - parameters `DATA_W`, `ADDR_W`;
  - ports `clk`, `reset`, two read address/data pairs, write address/data/enable;
  - owns the bypass and the `$0` rule.
- The top level holds the forwarding muxes, extender, adder, comparator and ID/EX register.

## Test plan
- Reset, then read every register → all 0; assert `reset` during a write of 5 → entry stays 0, `ValidE` = 0.
- Write `$8` = `0xDEADBEEF` with `Rs` = 8 in the same cycle → `A_E` = `0xDEADBEEF` after one edge (bypass); write `$0` = 7 → reads of `$0` still return 0.
- `ForwardAD` = 1 with `ALUOutM` = 0x55, `ForwardBD` = 2 with `ResultW` = 0x55 → `EqualD` = 1; change `ResultW` to 0x56 → `EqualD` = 0 in the same cycle.
- Immediate `0x8000`, `PCPlus4D` = 0x100 → `PCBranchD` = `0xFFFE0100`; `SignImmE` = `0xFFFF8000` with `ExtZeroD` = 0 and `0x00008000` with `ExtZeroD` = 1.
- `StallE` held 2 cycles while `InstrD` changes → all E outputs unchanged; `StallE` and `FlushE` together → bubble with all fields 0, `ValidE` = 0.
- `DATA_W` = 16, `ADDR_W` = 3, `PC_W` = 12: immediate `0xFFFF`, `PCPlus4D` = 0x004 → `PCBranchD` = 0x000; register 7 writes and reads correctly.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared forwarding codes and ID/EX field layout for the decode stage
package decode_pkg;
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic       valid;
  } idex_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: decode-stage datapath bundle; master drives decode inputs, slave is the stage
interface decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
);
  logic [31:0]       InstrD;
  logic [PC_W-1:0]   PCPlus4D;
  logic              ValidD;
  logic              ExtZeroD;
  logic [1:0]        ForwardAD;
  logic [1:0]        ForwardBD;
  logic [DATA_W-1:0] ALUOutM;
  logic [DATA_W-1:0] ResultW;
  logic [ADDR_W-1:0] WriteRegW;
  logic              RegWriteW;
  logic              StallE;
  logic              FlushE;
  logic [5:0]        Op;
  logic [5:0]        Funct;
  logic [ADDR_W-1:0] RsD;
  logic [ADDR_W-1:0] RtD;
  logic              EqualD;
  logic [PC_W-1:0]   PCBranchD;
  logic [DATA_W-1:0] A_E;
  logic [DATA_W-1:0] B_E;
  logic [DATA_W-1:0] SignImmE;
  logic [ADDR_W-1:0] RsE;
  logic [ADDR_W-1:0] RtE;
  logic [ADDR_W-1:0] RdE;
  logic [4:0]        ShamtE;
  logic              ValidE;
  modport master (
    output InstrD, PCPlus4D, ValidD, ExtZeroD, ForwardAD, ForwardBD, ALUOutM, ResultW,
           WriteRegW, RegWriteW, StallE, FlushE,
    input  Op, Funct, RsD, RtD, EqualD, PCBranchD, A_E, B_E, SignImmE, RsE, RtE, RdE,
           ShamtE, ValidE
  );
  modport slave (
    input  InstrD, PCPlus4D, ValidD, ExtZeroD, ForwardAD, ForwardBD, ALUOutM, ResultW,
           WriteRegW, RegWriteW, StallE, FlushE,
    output Op, Funct, RsD, RtD, EqualD, PCBranchD, A_E, B_E, SignImmE, RsE, RtE, RdE,
           ShamtE, ValidE
  );
endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with write-through bypass and hardwired $0
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              wr_ok;
  assign wr_ok = we && (wa != '0);
  // clear every entry on reset, otherwise commit writes to nonzero addresses
  always_ff @(posedge clk) begin
    if (reset)
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    else if (wr_ok)
      mem[wa] <= wd;
  end
  // $0 reads as zero; a same-cycle write to the read address is passed straight through
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : (wr_ok && wa == ra1) ? wd : mem[ra1];
    rd2 = (ra2 == '0) ? '0 : (wr_ok && wa == ra2) ? wd : mem[ra2];
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS decode with register file, forwarding, branch compare/target, immediate extend and ID/EX register
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);
  import decode_pkg::*;
  logic [DATA_W-1:0] rd1, rd2, rd1f, rd2f, sign_imm, ext_imm, a_e, b_e, imm_e;
  logic [PC_W-1:0]   br_off;
  idex_t             idex;
  assign bus.Op    = bus.InstrD[31:26];
  assign bus.Funct = bus.InstrD[5:0];
  assign bus.RsD   = bus.InstrD[21 +: ADDR_W];
  assign bus.RtD   = bus.InstrD[16 +: ADDR_W];
  regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (bus.RsD),
    .ra2   (bus.RtD),
    .rd1   (rd1),
    .rd2   (rd2),
    .wa    (bus.WriteRegW),
    .wd    (bus.ResultW),
    .we    (bus.RegWriteW)
  );
  // operand forwarding, immediate extension, branch compare and target
  always_comb begin
    rd1f      = (bus.ForwardAD == FWD_MEM) ? bus.ALUOutM : (bus.ForwardAD == FWD_WB) ? bus.ResultW : rd1;
    rd2f      = (bus.ForwardBD == FWD_MEM) ? bus.ALUOutM : (bus.ForwardBD == FWD_WB) ? bus.ResultW : rd2;
    sign_imm  = DATA_W'($signed(bus.InstrD[15:0]));
    ext_imm   = bus.ExtZeroD ? DATA_W'(bus.InstrD[15:0]) : sign_imm;
    br_off    = PC_W'($signed({bus.InstrD[15:0], 2'b00}));
    bus.EqualD    = (rd1f == rd2f);
    bus.PCBranchD = bus.PCPlus4D + br_off;
  end
  // ID/EX register: reset and flush load a bubble, stall holds, otherwise capture decode
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      a_e   <= '0;
      b_e   <= '0;
      imm_e <= '0;
      idex  <= '0;
    end else if (!bus.StallE) begin
      a_e   <= rd1f;
      b_e   <= rd2f;
      imm_e <= ext_imm;
      idex  <= '{rs: bus.InstrD[25:21], rt: bus.InstrD[20:16], rd: bus.InstrD[15:11],
                 shamt: bus.InstrD[10:6], valid: bus.ValidD};
    end
  end
  assign bus.A_E      = a_e;
  assign bus.B_E      = b_e;
  assign bus.SignImmE = imm_e;
  assign bus.RsE      = ADDR_W'(idex.rs);
  assign bus.RtE      = ADDR_W'(idex.rt);
  assign bus.RdE      = ADDR_W'(idex.rd);
  assign bus.ShamtE   = idex.shamt;
  assign bus.ValidE   = idex.valid;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table plus hand sequences for stall/flush/reset and a narrow instance
module tb_decode_stage;
  logic clk, reset;
  int   n_chk, n_fail;
  decode_stage_if #(.DATA_W(32), .ADDR_W(5), .PC_W(32)) b0 ();
  decode_stage_if #(.DATA_W(16), .ADDR_W(3), .PC_W(12)) b1 ();
  decode_stage #(.DATA_W(32), .ADDR_W(5), .PC_W(32)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  decode_stage #(.DATA_W(16), .ADDR_W(3), .PC_W(12)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  typedef struct {
    logic [31:0] instr, pc4;
    logic        vd, ez;
    logic [1:0]  fa, fb;
    logic [31:0] alu, res;
    logic [4:0]  wr;
    logic        rw;
    logic        eq;
    logic [31:0] pcb, a, b, imm;
    logic [4:0]  rs, rt, rd, sh;
    logic        ve;
  } vec_t;
  vec_t v [10];
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_e(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sh, input logic ve);
    chk({tag, "_A_E"}, b0.A_E, a);
    chk({tag, "_B_E"}, b0.B_E, b);
    chk({tag, "_SignImmE"}, b0.SignImmE, imm);
    chk({tag, "_RsE"}, 32'(b0.RsE), 32'(rs));
    chk({tag, "_RtE"}, 32'(b0.RtE), 32'(rt));
    chk({tag, "_RdE"}, 32'(b0.RdE), 32'(rd));
    chk({tag, "_ShamtE"}, 32'(b0.ShamtE), 32'(sh));
    chk({tag, "_ValidE"}, 32'(b0.ValidE), 32'(ve));
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1;
    {b0.InstrD, b0.PCPlus4D, b0.ValidD, b0.ExtZeroD, b0.ForwardAD, b0.ForwardBD} = '0;
    {b0.ALUOutM, b0.StallE, b0.FlushE} = '0;
    b0.RegWriteW = 1;
    b0.WriteRegW = 5;
    b0.ResultW = 5;
    {b1.InstrD, b1.PCPlus4D, b1.ValidD, b1.ExtZeroD, b1.ForwardAD, b1.ForwardBD} = '0;
    {b1.ALUOutM, b1.ResultW, b1.WriteRegW, b1.RegWriteW, b1.StallE, b1.FlushE} = '0;
    tick;
    tick;
    chk_e("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    b0.RegWriteW = 0;
    b0.ValidD = 1;
    for (int r = 0; r < 32; r++) begin
      b0.InstrD = itype(6'h0, r[4:0], r[4:0], 16'h0);
      tick;
      chk($sformatf("rdall%0d_A", r), b0.A_E, 0);
      chk($sformatf("rdall%0d_B", r), b0.B_E, 0);
      chk($sformatf("rdall%0d_V", r), 32'(b0.ValidE), 1);
    end
    v[0] = '{itype(6'h4, 5'd8, 5'd0, 16'h0010), 32'h100, 1, 0, 0, 0, 0, 32'hDEADBEEF, 5'd8, 1,
             0, 32'h140, 32'hDEADBEEF, 0, 32'h10, 5'd8, 5'd0, 5'd0, 5'd0, 1};
    v[1] = '{itype(6'h4, 5'd8, 5'd8, 16'h0), 32'h100, 1, 0, 0, 0, 0, 0, 5'd0, 0,
             1, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 0, 5'd8, 5'd8, 5'd0, 5'd0, 1};
    v[2] = '{itype(6'h4, 5'd0, 5'd0, 16'h0), 32'h100, 1, 0, 0, 0, 0, 7, 5'd0, 1,
             1, 32'h100, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 1};
    v[3] = '{itype(6'h0, 5'd1, 5'd2, 16'h0), 32'h100, 1, 0, 1, 2, 32'h55, 32'h55, 5'd0, 0,
             1, 32'h100, 32'h55, 32'h55, 0, 5'd1, 5'd2, 5'd0, 5'd0, 1};
    v[4] = '{itype(6'h0, 5'd1, 5'd2, 16'h0), 32'h100, 1, 0, 1, 2, 32'h55, 32'h56, 5'd0, 0,
             0, 32'h100, 32'h55, 32'h56, 0, 5'd1, 5'd2, 5'd0, 5'd0, 1};
    v[5] = '{itype(6'h4, 5'd8, 5'd0, 16'h8000), 32'h100, 1, 0, 3, 0, 0, 0, 5'd0, 0,
             0, 32'hFFFE0100, 32'hDEADBEEF, 0, 32'hFFFF8000, 5'd8, 5'd0, 5'd16, 5'd0, 1};
    v[6] = '{itype(6'h4, 5'd8, 5'd0, 16'h8000), 32'h100, 1, 1, 3, 0, 0, 0, 5'd0, 0,
             0, 32'hFFFE0100, 32'hDEADBEEF, 0, 32'h00008000, 5'd8, 5'd0, 5'd16, 5'd0, 1};
    v[7] = '{itype(6'h4, 5'd9, 5'd8, 16'h5A5A), 32'h100, 0, 0, 0, 0, 0, 32'h12345678, 5'd9, 1,
             0, 32'h16A68, 32'h12345678, 32'hDEADBEEF, 32'h5A5A, 5'd9, 5'd8, 5'd11, 5'd9, 0};
    v[8] = '{itype(6'h4, 5'd9, 5'd9, 16'hFFFF), 32'h100, 1, 0, 0, 0, 0, 0, 5'd0, 0,
             1, 32'hFC, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 5'd9, 5'd9, 5'd31, 5'd31, 1};
    v[9] = '{itype(6'h4, 5'd8, 5'd9, 16'h7FFF), 32'h100, 1, 1, 0, 0, 0, 0, 5'd0, 0,
             0, 32'h200FC, 32'hDEADBEEF, 32'h12345678, 32'h7FFF, 5'd8, 5'd9, 5'd15, 5'd31, 1};
    for (int i = 0; i < 10; i++) begin
      b0.InstrD = v[i].instr;
      b0.PCPlus4D = v[i].pc4;
      b0.ValidD = v[i].vd;
      b0.ExtZeroD = v[i].ez;
      b0.ForwardAD = v[i].fa;
      b0.ForwardBD = v[i].fb;
      b0.ALUOutM = v[i].alu;
      b0.ResultW = v[i].res;
      b0.WriteRegW = v[i].wr;
      b0.RegWriteW = v[i].rw;
      #1;
      chk($sformatf("v%0d_EqualD", i), 32'(b0.EqualD), 32'(v[i].eq));
      chk($sformatf("v%0d_PCBranchD", i), b0.PCBranchD, v[i].pcb);
      tick;
      chk_e($sformatf("v%0d", i), v[i].a, v[i].b, v[i].imm, v[i].rs, v[i].rt, v[i].rd, v[i].sh, v[i].ve);
    end
    b0.RegWriteW = 0;
    b0.ForwardAD = 1;
    b0.ForwardBD = 0;
    b0.ALUOutM = 32'hAAAA;
    b0.ValidD = 1;
    b0.InstrD = itype(6'h2B, 5'd1, 5'd2, 16'h1234);
    #1;
    chk("comb_Op", 32'(b0.Op), 32'h2B);
    chk("comb_Funct", 32'(b0.Funct), 32'h34);
    chk("comb_RsD", 32'(b0.RsD), 1);
    chk("comb_RtD", 32'(b0.RtD), 2);
    b0.StallE = 1;
    tick;
    chk_e("stall1", 32'hDEADBEEF, 32'h12345678, 32'h7FFF, 5'd8, 5'd9, 5'd15, 5'd31, 1);
    b0.InstrD = itype(6'h4, 5'd9, 5'd9, 16'hFFFF);
    tick;
    chk_e("stall2", 32'hDEADBEEF, 32'h12345678, 32'h7FFF, 5'd8, 5'd9, 5'd15, 5'd31, 1);
    b0.FlushE = 1;
    tick;
    chk_e("stflush", 0, 0, 0, 0, 0, 0, 0, 0);
    b0.StallE = 0;
    b0.FlushE = 0;
    b0.InstrD = itype(6'h2B, 5'd1, 5'd2, 16'h1234);
    tick;
    chk("resume_A_E", b0.A_E, 32'hAAAA);
    chk("resume_RdE", 32'(b0.RdE), 2);
    chk("resume_ValidE", 32'(b0.ValidE), 1);
    reset = 1;
    b0.RegWriteW = 1;
    b0.WriteRegW = 10;
    b0.ResultW = 32'hCAFE;
    tick;
    chk_e("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    b0.RegWriteW = 0;
    b0.ForwardAD = 0;
    b0.InstrD = itype(6'h4, 5'd8, 5'd10, 16'h0);
    tick;
    chk("midrst_r8", b0.A_E, 0);
    chk("midrst_r10", b0.B_E, 0);
    chk("midrst_ValidE", 32'(b0.ValidE), 1);
    b1.RegWriteW = 1;
    b1.WriteRegW = 7;
    b1.ResultW = 16'hBEEF;
    tick;
    b1.RegWriteW = 0;
    b1.ValidD = 1;
    b1.InstrD = itype(6'h4, 5'd15, 5'd7, 16'hFFFF);
    b1.PCPlus4D = 12'h004;
    #1;
    chk("n_RsD", 32'(b1.RsD), 7);
    chk("n_PCBranchD", 32'(b1.PCBranchD), 0);
    chk("n_EqualD", 32'(b1.EqualD), 1);
    tick;
    chk("n_A_E", 32'(b1.A_E), 32'hBEEF);
    chk("n_B_E", 32'(b1.B_E), 32'hBEEF);
    chk("n_SignImmE", 32'(b1.SignImmE), 32'hFFFF);
    chk("n_RsE", 32'(b1.RsE), 7);
    chk("n_ValidE", 32'(b1.ValidE), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
